// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types for the sequential shift-add multiplier.
package seq_shift_add_multiplier_pkg;

  // Controller states; the encoding is fixed at 2 bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_dp.sv
// Shift-add datapath: operand magnitude capture, conditional add,
// right shift and final sign correction of the product.
module mult_shift_add_dp #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] p
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg;

  logic [WIDTH-1:0]   m_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH:0]     sum;

  // Magnitudes of the operands. Negating -2^(WIDTH-1) wraps back to the
  // same bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    m_mag = (is_signed && m[WIDTH-1]) ? -m : m;
    q_mag = (is_signed && q[WIDTH-1]) ? -q : q;
  end

  // Upper half plus the multiplicand when the current multiplier bit is
  // set; the extra bit keeps the carry so the shift loses nothing.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) sum = sum + {1'b0, mcand};
  end

  // Accumulator: lower half starts as the multiplier and is consumed one
  // bit per step while the partial sum grows into the upper half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      mcand <= m_mag;
      acc   <= {{WIDTH{1'b0}}, q_mag};
      neg   <= is_signed & (m[WIDTH-1] ^ q[WIDTH-1]);
    end else if (step) begin
      acc   <= {sum, acc[WIDTH-1:1]};
    end
  end

  // Product register: only written once the magnitude product is complete,
  // so intermediate sums never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else if (fix) p <= neg ? -acc : acc;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes; holds the
// controller, iteration counter and handshake logic.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load, step, fix;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter: cleared on accept, advanced once per add/shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CNT_W'(1);
  end

  // Next state, datapath enables and handshake outputs. RUN spends one
  // extra cycle after the last step to see the terminal count, which
  // places out_valid WIDTH+2 edges after the accepting edge.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH)) state_nxt = FIX;
        else                      step      = 1'b1;
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .m         (m),
    .q         (q),
    .is_signed (is_signed),
    .p         (p)
  );

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for the shift-add multiplier (WIDTH=4 and WIDTH=8 instances).
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       iv4 = 1'b0, ir4, ov4, ordy4 = 1'b0, s4 = 1'b0, busy4;
  logic [3:0] m4 = '0, q4 = '0;
  logic [7:0] p4;

  // WIDTH=8 instance
  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b0, s8 = 1'b0, busy8;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [15:0] p8;

  int n_chk = 0;
  int n_fail = 0;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .m(m4), .q(q4),
    .is_signed(s4), .out_valid(ov4), .out_ready(ordy4), .p(p4), .busy(busy4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .m(m8), .q(q8),
    .is_signed(s8), .out_valid(ov8), .out_ready(ordy8), .p(p8), .busy(busy8)
  );

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int x, y, r;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    r = x * y;
    return r[7:0];
  endfunction

  // One WIDTH=4 transaction from IDLE; reports product, latency, whether
  // in_ready stayed low until the output handshake, and output stability.
  task automatic run4(input logic [3:0] mm, input logic [3:0] qq, input logic s,
                      input int bp, output logic [7:0] pr, output int lat,
                      output bit rdy_low, output bit stable);
    rdy_low = 1'b1; stable = 1'b1; lat = 0;
    m4 = mm; q4 = qq; s4 = s; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    while (!ov4 && lat < 40) begin
      if (ir4) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    pr = p4;
    if (ir4) rdy_low = 1'b0;
    repeat (bp) begin
      @(posedge clk); #1;
      if (ir4) rdy_low = 1'b0;
      if (p4 !== pr || ov4 !== 1'b1) stable = 1'b0;
    end
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] mm, input logic [7:0] qq, input logic s,
                      output logic [15:0] pr, output int lat);
    lat = 0;
    m8 = mm; q8 = qq; s8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = p8;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_chk++; if (ir4 !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir4); end
    n_chk++; if (ov4 !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov4); end
    n_chk++; if (busy4 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy4); end
    n_chk++; if (p4 !== 8'h00)    begin n_fail++; $display("FAIL reset_p got %h want 00", p4); end
    n_chk++; if (p8 !== 16'h0000) begin n_fail++; $display("FAIL reset_p8 got %h want 0000", p8); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max;
    logic [7:0] pr; int lat; bit rl, st;
    run4(4'hF, 4'hF, 1'b0, 2, pr, lat, rl, st);
    n_chk++; if (pr !== 8'hE1) begin n_fail++; $display("FAIL umax_p got %h want e1", pr); end
    n_chk++; if (lat !== 6)    begin n_fail++; $display("FAIL umax_latency got %0d want 6", lat); end
    n_chk++; if (rl !== 1'b1)  begin n_fail++; $display("FAIL umax_in_ready_low got %b want 1", rl); end
    n_chk++; if (st !== 1'b1)  begin n_fail++; $display("FAIL umax_p_stable got %b want 1", st); end
  endtask

  task automatic test_signed;
    logic [7:0] pr; int lat; bit rl, st;
    run4(4'h8, 4'h7, 1'b1, 0, pr, lat, rl, st);
    n_chk++; if (pr !== 8'hC8) begin n_fail++; $display("FAIL signed_m8x7 got %h want c8", pr); end
    run4(4'h8, 4'h8, 1'b1, 1, pr, lat, rl, st);
    n_chk++; if (pr !== 8'h40) begin n_fail++; $display("FAIL signed_m8xm8 got %h want 40", pr); end
    n_chk++; if (lat !== 6)    begin n_fail++; $display("FAIL signed_latency got %0d want 6", lat); end
    // p holds its value after the output handshake
    @(posedge clk); #1;
    n_chk++; if (p4 !== 8'h40) begin n_fail++; $display("FAIL p_hold_after_done got %h want 40", p4); end
  endtask

  task automatic test_busy;
    int lat;
    m4 = 4'd3; q4 = 4'd5; s4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    m4 = 4'd9; q4 = 4'd9;
    n_chk++; if (ir4 !== 1'b0 || busy4 !== 1'b1) begin
      n_fail++; $display("FAIL busy_run_flags got ir=%b busy=%b want 0 1", ir4, busy4); end
    lat = 0;
    while (!ov4 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_chk++; if (p4 !== 8'd15) begin n_fail++; $display("FAIL busy_first_p got %0d want 15", p4); end
    n_chk++; if (lat !== 6)    begin n_fail++; $display("FAIL busy_latency got %0d want 6", lat); end
    n_chk++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL busy_done_in_ready got %b want 0", ir4); end
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
    n_chk++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL busy_back_idle got %b want 1", ir4); end
    @(posedge clk); #1;
    iv4 = 1'b0;
    n_chk++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL busy_second_accept got %b want 1", busy4); end
    lat = 0;
    while (!ov4 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_chk++; if (p4 !== 8'd81) begin n_fail++; $display("FAIL busy_second_p got %0d want 81", p4); end
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] pr; int lat; bit rl, st;
    m4 = 4'd12; q4 = 4'd11; s4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (ov4 !== 1'b0)   begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", ov4); end
    n_chk++; if (p4 !== 8'h00)   begin n_fail++; $display("FAIL midrst_p got %h want 00", p4); end
    n_chk++; if (ir4 !== 1'b1)   begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", ir4); end
    n_chk++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy4); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run4(4'd2, 4'd3, 1'b0, 0, pr, lat, rl, st);
    n_chk++; if (pr !== 8'd6) begin n_fail++; $display("FAIL midrst_next_p got %0d want 6", pr); end
  endtask

  task automatic test_zero;
    logic [7:0] pr; int lat; bit rl, st;
    run4(4'd0, 4'd13, 1'b0, 0, pr, lat, rl, st);
    n_chk++; if (pr !== 8'd0) begin n_fail++; $display("FAIL zero_p got %0d want 0", pr); end
    n_chk++; if (lat !== 6)   begin n_fail++; $display("FAIL zero_latency got %0d want 6", lat); end
  endtask

  task automatic test_sweep4;
    logic [7:0] pr, ex; int lat; bit rl, st;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          run4(4'(a), 4'(b), 1'(s), int'($urandom_range(0, 2)), pr, lat, rl, st);
          ex = ref4(4'(a), 4'(b), 1'(s));
          n_chk++; if (pr !== ex) begin n_fail++;
            $display("FAIL sweep_p s=%0d m=%0d q=%0d got %h want %h", s, a, b, pr, ex); end
          n_chk++; if (st !== 1'b1) begin n_fail++;
            $display("FAIL sweep_stable s=%0d m=%0d q=%0d got %b want 1", s, a, b, st); end
          n_chk++; if (lat !== 6) begin n_fail++;
            $display("FAIL sweep_latency s=%0d m=%0d q=%0d got %0d want 6", s, a, b, lat); end
        end
  endtask

  task automatic test_width8;
    logic [15:0] pr; int lat;
    run8(8'hFF, 8'hFF, 1'b0, pr, lat);
    n_chk++; if (pr !== 16'hFE01) begin n_fail++; $display("FAIL w8_umax got %h want fe01", pr); end
    n_chk++; if (lat !== 10)      begin n_fail++; $display("FAIL w8_latency got %0d want 10", lat); end
    run8(8'h80, 8'h80, 1'b1, pr, lat);
    n_chk++; if (pr !== 16'h4000) begin n_fail++; $display("FAIL w8_minsq got %h want 4000", pr); end
    run8(8'h80, 8'h7F, 1'b1, pr, lat);
    n_chk++; if (pr !== 16'hC080) begin n_fail++; $display("FAIL w8_min_x_max got %h want c080", pr); end
    run8(8'hFF, 8'hFF, 1'b1, pr, lat);
    n_chk++; if (pr !== 16'h0001) begin n_fail++; $display("FAIL w8_m1_x_m1 got %h want 0001", pr); end
    run8(8'h12, 8'h34, 1'b0, pr, lat);
    n_chk++; if (pr !== 16'h03A8) begin n_fail++; $display("FAIL w8_12x34 got %h want 03a8", pr); end
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_signed;
    test_busy;
    test_reset_mid_run;
    test_zero;
    test_sweep4;
    test_width8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
